fc_argmax: RTL

- Downstream of the fully-connected stage. Starts on fc2_done and reads the CLASS_NUM signed 8-bit fc2 scores from SRAM f.
- Reports the index and value of the largest score as the network's classification result.
- Scores are packed DATA_NUM_PER_SRAM_ADDR per SRAM word. Score k lives at address BASE_ADDR + k/4, lane k%4; lane 0 is bits [31:24] and lane 3 is bits [7:0].

---
 rtl/fc_pkg.sv | 20 ++
 rtl/argmax_lane4.sv | 31 +++
 rtl/fc_argmax.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants, state encoding and helpers for the fc2 argmax stage.
package fc_pkg;

  localparam int unsigned DATA_WIDTH             = 8;
  localparam int unsigned DATA_NUM_PER_SRAM_ADDR = 4;
  localparam int unsigned CLASS_NUM              = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of SRAM words needed to hold n scores packed per to a word.
  function automatic int unsigned nwords(input int unsigned n, input int unsigned per);
    return (n + per - 1) / per;
  endfunction

endpackage

// File: rtl/argmax_lane4.sv
// Folds one packed SRAM word of scores into a running max/index; lowest index wins ties.
module argmax_lane4 #(
  parameter int unsigned DATA_WIDTH = fc_pkg::DATA_WIDTH,
  parameter int unsigned LANES      = fc_pkg::DATA_NUM_PER_SRAM_ADDR,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic [LANES*DATA_WIDTH-1:0]  scores,
  input  logic [LANES-1:0]             lane_valid,
  input  logic signed [DATA_WIDTH-1:0] in_max,
  input  logic [IDX_WIDTH-1:0]         in_idx,
  input  logic [IDX_WIDTH-1:0]         base_idx,
  output logic signed [DATA_WIDTH-1:0] out_max_c,
  output logic [IDX_WIDTH-1:0]         out_idx_c
);

  // Lane 0 sits in the top byte; scan lanes in ascending index, replace only on strictly greater.
  always_comb begin : lane_scan
    logic signed [DATA_WIDTH-1:0] lane;
    lane      = '0;
    out_max_c = in_max;
    out_idx_c = in_idx;
    for (int l = 0; l < int'(LANES); l++) begin
      lane = scores[(int'(LANES) - 1 - l) * int'(DATA_WIDTH) +: DATA_WIDTH];
      if (lane_valid[l] && (lane > out_max_c)) begin
        out_max_c = lane;
        out_idx_c = base_idx + IDX_WIDTH'(l);
      end
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Reads the fc2 scores from SRAM f after fc2_done and reports the argmax class.
module fc_argmax #(
  parameter int unsigned DATA_WIDTH             = fc_pkg::DATA_WIDTH,
  parameter int unsigned DATA_NUM_PER_SRAM_ADDR = fc_pkg::DATA_NUM_PER_SRAM_ADDR,
  parameter int unsigned CLASS_NUM              = fc_pkg::CLASS_NUM,
  parameter int unsigned ADDR_WIDTH             = 10,
  parameter int unsigned BASE_ADDR              = 0,
  parameter int unsigned IDX_WIDTH              = 4
) (
  input  logic                                   clk,
  input  logic                                   srstn,
  input  logic                                   fc2_done,
  output logic [ADDR_WIDTH-1:0]                  sram_raddr_f,
  input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
  output logic                                   busy,
  output logic                                   result_valid,
  output logic [IDX_WIDTH-1:0]                   class_idx,
  output logic [DATA_WIDTH-1:0]                  class_score
);

  import fc_pkg::*;

  localparam int unsigned NW     = nwords(CLASS_NUM, DATA_NUM_PER_SRAM_ADDR);
  localparam int unsigned WCNT_W = $clog2(NW + 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + NW - 1);
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state, state_nxt;
  logic signed [DATA_WIDTH-1:0]   run_max;
  logic [IDX_WIDTH-1:0]           run_idx;
  logic [WCNT_W-1:0]              wcnt;

  logic                           cmp_en_c;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] lane_valid_c;
  logic [IDX_WIDTH-1:0]           base_idx_c;
  logic signed [DATA_WIDTH-1:0]   word_max_c;
  logic [IDX_WIDTH-1:0]           word_idx_c;

  // Next-state logic and compare enable: read data lags the address by one cycle.
  always_comb begin
    state_nxt = state;
    cmp_en_c  = 1'b0;
    case (state)
      IDLE:  if (fc2_done) state_nxt = FETCH;
      FETCH: begin
        cmp_en_c = (sram_raddr_f != FIRST_ADDR);
        if (sram_raddr_f == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        cmp_en_c  = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mask lanes beyond the last class and derive the global index of lane 0.
  always_comb begin
    lane_valid_c = '0;
    for (int l = 0; l < int'(DATA_NUM_PER_SRAM_ADDR); l++) begin
      lane_valid_c[l] = ((32'(wcnt) * DATA_NUM_PER_SRAM_ADDR + 32'(l)) < CLASS_NUM);
    end
    base_idx_c = IDX_WIDTH'(32'(wcnt) * DATA_NUM_PER_SRAM_ADDR);
  end

  argmax_lane4 #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (DATA_NUM_PER_SRAM_ADDR),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_lane4 (
    .scores     (sram_rdata_f),
    .lane_valid (lane_valid_c),
    .in_max     (run_max),
    .in_idx     (run_idx),
    .base_idx   (base_idx_c),
    .out_max_c  (word_max_c),
    .out_idx_c  (word_idx_c)
  );

  // State, address counter, running max and result registers.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state        <= IDLE;
      sram_raddr_f <= FIRST_ADDR;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      run_max      <= SCORE_MIN;
      run_idx      <= '0;
      wcnt         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (fc2_done) begin
            sram_raddr_f <= FIRST_ADDR;
            busy         <= 1'b1;
            run_max      <= SCORE_MIN;
            run_idx      <= '0;
            wcnt         <= '0;
          end
        end
        FETCH: begin
          if (sram_raddr_f != LAST_ADDR) sram_raddr_f <= sram_raddr_f + ADDR_WIDTH'(1);
        end
        DRAIN: begin
          result_valid <= 1'b1;
          class_idx    <= word_idx_c;
          class_score  <= word_max_c;
        end
        DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: ;
      endcase
      if (cmp_en_c) begin
        run_max <= word_max_c;
        run_idx <= word_idx_c;
        wcnt    <= wcnt + WCNT_W'(1);
      end
    end
  end

endmodule
